// File: rtl/pdm_interp.sv
// PCM to 1-bit PDM: 2-stage zero-stuffing CIC interpolator,
// shift/saturate normaliser and first-order sigma-delta modulator.
module pdm_interp #(
  parameter int WIDTH = 24,
  parameter int RATE  = 49,
  parameter int ACC_W = 32,
  parameter int SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    underrun,
  output logic                    dout
);

  localparam int PW = $clog2(RATE);
  localparam int EW = WIDTH + 2;
  localparam logic [PW-1:0] LAST = PW'(RATE - 1);
  localparam logic signed [ACC_W-1:0] PMAX =
    ACC_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] NMIN =
    ACC_W'(-(64'sd1 <<< (WIDTH - 1)));
  localparam logic signed [EW-1:0] FULL =
    EW'(64'sd1 <<< (WIDTH - 1));

  logic [PW-1:0] phase;
  logic signed [WIDTH-1:0] x_reg;
  logic signed [WIDTH-1:0] sel;
  logic signed [ACC_W-1:0] c0, c1, i0, i1;
  logic signed [ACC_W-1:0] s, d, u, sh;
  logic signed [WIDTH-1:0] m;
  logic signed [EW-1:0] e, v, e_nx;
  logic pos;

  assign in_ready = (phase == LAST);

  // A missing sample repeats the previous one.
  always_comb begin
    sel = in_valid ? in_data : x_reg;
    s   = ACC_W'(sel);
    d   = s - ACC_W'(x_reg);
    u   = (phase == '0) ? c1 : '0;
  end

  always_comb begin
    sh = i1 >>> SHIFT;
    m  = sh[WIDTH-1:0];
    if (sh > PMAX)
      m = {1'b0, {(WIDTH-1){1'b1}}};
    else if (sh < NMIN)
      m = {1'b1, {(WIDTH-1){1'b0}}};
  end

  always_comb begin
    v    = e + EW'(m);
    pos  = ~v[EW-1];
    e_nx = pos ? (v - FULL) : (v + FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= '0;
      x_reg    <= '0;
      c0       <= '0;
      c1       <= '0;
      underrun <= 1'b0;
    end else begin
      phase    <= in_ready ? '0 : phase + PW'(1);
      underrun <= 1'b0;
      if (in_ready) begin
        x_reg    <= sel;
        c0       <= d;
        c1       <= d - c0;
        underrun <= ~in_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i0   <= '0;
      i1   <= '0;
      e    <= '0;
      dout <= 1'b0;
    end else begin
      i0   <= i0 + u;
      i1   <= i1 + i0;
      e    <= e_nx;
      dout <= pos;
    end
  end

endmodule
